mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single unified instruction/data memory port between the fetch unit (read-only) and the load/store unit (read/write) of the multicycle core. It latches one request at a time, sequences the memory handshake, and returns a registered one-cycle done pulse to the owning requester. A per-transaction watchdog returns an error response if memory never answers.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; wmask width is DATA_W/8
TIMEOUT_CYCLES, 16, BUSY cycles without mem_ready before error response; 0 disables watchdog

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch read request; held high, fields stable, until i_done
i_addr  in  ADDR_W  fetch address
i_done  out  1  one-cycle completion pulse to fetch
i_rdata  out  DATA_W  fetch read data, valid while i_done=1
i_err  out  1  fetch timeout flag, valid while i_done=1
d_req  in  1  load/store request; held until d_done
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_wmask  in  DATA_W/8  byte enables for writes
d_done  out  1  one-cycle completion pulse to load/store
d_rdata  out  DATA_W  load data, valid while d_done=1
d_err  out  1  data timeout flag, valid while d_done=1
mem_valid  out  1  memory request valid
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wmask  out  DATA_W/8  memory byte enables (all 0 on reads)
mem_ready  in  1  memory completion, one cycle
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
busy  out  1  state != IDLE
owner  out  1  0 = fetch, 1 = data; owner of current or last transaction

Behaviour:
- Reset: state IDLE; all outputs 0; last_grant = 1 (data), so fetch wins the first tie; watchdog 0.
- States: IDLE, BUSY, RESP.
- IDLE: requests are sampled here only.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester != last_grant (round-robin).
  - On grant: latch addr/we/wdata/wmask into registers. Fetch grants force we=0 and wmask=0.
  - Update last_grant and owner, clear watchdog, go to BUSY.
  - No req: stay in IDLE.
- BUSY:
  - mem_valid=1; mem_* driven from the latched registers, stable for the whole state.
  - On mem_ready: capture mem_rdata (0 for writes), err=0, go to RESP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES (nonzero), capture rdata=0, err=1, go to RESP.
  - A mem_ready in the same cycle the watchdog hits the limit counts as success.
- RESP:
  - mem_valid=0; the owner's done=1 for exactly this cycle, with rdata/err registered.
  - The other requester's done/rdata/err stay 0. Unconditionally return to IDLE.
  - RESP isolates req sampling from the done cycle: a requester that drops req on seeing done is never granted twice.
- Latency: req high in IDLE cycle t with mem_ready in its first BUSY cycle (t+1) gives done in cycle t+2. Each extra memory wait cycle adds one cycle.
- Requester fields may change after grant without effect; only the latched copy drives memory.
- A requester that still holds req in the IDLE cycle after its RESP is treated as a new request. A tie in that cycle goes to the other requester.
- mem_ready outside BUSY is ignored.
- Reset asserted in any state: at that edge return to the reset values above. The in-flight transaction is abandoned with no done pulse, and mem_valid is 0 from the next cycle.
- Watchdog width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit; saturates, no wrap.

Test Plan:
- Fetch read: i_req=1, i_addr=0x10; memory answers mem_ready with 0x005100E7 on the first BUSY cycle -> mem_addr=0x10, mem_we=0, mem_wmask=0; i_done=1 two cycles after the request, i_rdata=0x005100E7, d_done stays 0.
- Tie: i_req and d_req high in the same cycle after reset -> fetch granted first (owner=0). Fetch drops req after done; d_req is still held -> data granted next (owner=1). Repeat the tie -> data is not granted twice in a row while fetch waits.
- Data write: d_we=1, d_addr=0x104, d_wdata=0xDEADBEEF, d_wmask=0b0011; mem_ready after 3 wait cycles -> mem_* stable for 4 BUSY cycles, d_done=1 with d_rdata=0, d_err=0.
- Timeout: TIMEOUT_CYCLES=16, d_req read, memory never answers -> exactly 16 BUSY cycles, then d_done=1, d_err=1, d_rdata=0, then IDLE.
- Timeout boundary: mem_ready arrives in the 16th BUSY cycle -> success (err=0), rdata equals mem_rdata.
- Reset mid-BUSY: assert reset in the second BUSY cycle -> next cycle busy=0, mem_valid=0, no done pulse. After release, a fresh i_req completes normally with fetch winning any tie.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between fetch and load/store.
// One latched transaction at a time, registered done pulse, per-transaction watchdog.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_done,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_err,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wmask,
   output logic                d_done,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_err,
   output logic                mem_valid,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy,
   output logic                owner
);

   localparam int unsigned WD_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W:0] WD_LIMIT = (WD_W + 1)'(TIMEOUT_CYCLES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]          state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] wmask_q, wmask_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                grant_i, grant_d;
   logic [WD_W:0]       wd_inc;

   // last_grant_q = 1 means data was served last, so fetch wins the next tie
   assign grant_i = i_req & (~d_req | last_grant_q);
   assign grant_d = d_req & (~i_req | ~last_grant_q);
   assign wd_inc  = {1'b0, wd_q} + (WD_W + 1)'(1);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      wd_d         = wd_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_i || grant_d) begin
               state_d      = ST_BUSY;
               owner_d      = grant_d;
               last_grant_d = grant_d;
               wd_d         = '0;
               if (grant_d) begin
                  addr_d  = d_addr;
                  we_d    = d_we;
                  wdata_d = d_wdata;
                  wmask_d = d_we ? d_wmask : '0;
               end else begin
                  addr_d  = i_addr;
                  we_d    = 1'b0;
                  wdata_d = '0;
                  wmask_d = '0;
               end
            end
         end
         ST_BUSY: begin
            if (mem_ready) begin
               state_d = ST_RESP;
               rdata_d = we_q ? '0 : mem_rdata;
               err_d   = 1'b0;
            end else begin
               if (!wd_inc[WD_W]) wd_d = wd_inc[WD_W-1:0];
               if (TIMEOUT_CYCLES != 0 && wd_inc == WD_LIMIT) begin
                  state_d = ST_RESP;
                  rdata_d = '0;
                  err_d   = 1'b1;
               end
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         wd_q         <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         wd_q         <= wd_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   logic in_busy, resp_i, resp_d;
   assign in_busy = (state_q == ST_BUSY);
   assign resp_i  = (state_q == ST_RESP) & ~owner_q;
   assign resp_d  = (state_q == ST_RESP) & owner_q;

   assign mem_valid = in_busy;
   assign mem_we    = in_busy & we_q;
   assign mem_addr  = in_busy ? addr_q  : '0;
   assign mem_wdata = in_busy ? wdata_q : '0;
   assign mem_wmask = in_busy ? wmask_q : '0;

   assign i_done  = resp_i;
   assign i_rdata = resp_i ? rdata_q : '0;
   assign i_err   = resp_i & err_q;
   assign d_done  = resp_d;
   assign d_rdata = resp_d ? rdata_q : '0;
   assign d_err   = resp_d & err_q;

   assign busy  = (state_q != ST_IDLE);
   assign owner = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = DW / 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req, d_req, d_we, mem_ready;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata, mem_rdata;
   logic [MW-1:0] d_wmask;
   logic          i_done, i_err, d_done, d_err, mem_valid, mem_we, busy, owner;
   logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic [MW-1:0] mem_wmask;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
      .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Transaction-level model: an outstanding memory transaction and/or a due response
   bit            m_txn = 0, m_resp = 0, m_last = 1, m_owner = 0, m_we = 0, m_err = 0;
   int            m_age = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0, m_rdata = '0;
   logic [MW-1:0] m_wmask = '0;

   task automatic model_update(input bit rst, input bit ir, input logic [AW-1:0] ia,
                               input bit dr, input bit dwe, input logic [AW-1:0] da,
                               input logic [DW-1:0] dwd, input logic [MW-1:0] dwm,
                               input bit rdy, input logic [DW-1:0] rd);
      bit win_d;
      if (rst) begin
         m_txn = 0; m_resp = 0; m_last = 1; m_owner = 0;
      end else if (m_resp) begin
         m_resp = 0;
      end else if (m_txn) begin
         m_age++;
         if (rdy) begin
            m_txn = 0; m_resp = 1; m_err = 0;
            m_rdata = m_we ? '0 : rd;
         end else if (TO != 0 && m_age == TO) begin
            m_txn = 0; m_resp = 1; m_err = 1; m_rdata = '0;
         end
      end else if (ir || dr) begin
         win_d   = (ir && dr) ? !m_last : dr;
         m_txn   = 1; m_age = 0; m_owner = win_d; m_last = win_d;
         m_addr  = win_d ? da : ia;
         m_we    = win_d && dwe;
         m_wdata = dwd;
         m_wmask = m_we ? dwm : '0;
      end
   endtask

   task automatic compare_model();
      bit ri, rdd;
      ri  = m_resp && !m_owner;
      rdd = m_resp && m_owner;
      chk("busy", busy, m_txn || m_resp);
      chk("owner", owner, m_owner);
      chk("mem_valid", mem_valid, m_txn);
      chk("mem_we", mem_we, m_txn && m_we);
      chk("mem_addr", mem_addr, m_txn ? m_addr : '0);
      chk("mem_wmask", mem_wmask, m_txn ? m_wmask : '0);
      if (m_txn && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      chk("i_done", i_done, ri);
      chk("i_rdata", i_rdata, ri ? m_rdata : '0);
      chk("i_err", i_err, ri && m_err);
      chk("d_done", d_done, rdd);
      chk("d_rdata", d_rdata, rdd ? m_rdata : '0);
      chk("d_err", d_err, rdd && m_err);
   endtask

   // Inputs are stable from #1 after an edge up to the next edge; sample them, then clock.
   task automatic step();
      bit            s_rst, s_ir, s_dr, s_dwe, s_rdy;
      logic [AW-1:0] s_ia, s_da;
      logic [DW-1:0] s_dwd, s_rd;
      logic [MW-1:0] s_dwm;
      s_rst = reset; s_ir = i_req; s_ia = i_addr; s_dr = d_req; s_dwe = d_we; s_da = d_addr;
      s_dwd = d_wdata; s_dwm = d_wmask; s_rdy = mem_ready; s_rd = mem_rdata;
      @(posedge clk);
      model_update(s_rst, s_ir, s_ia, s_dr, s_dwe, s_da, s_dwd, s_dwm, s_rdy, s_rd);
      #1;
      compare_model();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int busy_cnt, n;
      bit stall;
      reset = 1; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0; mem_rdata = '0;
      step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_owner", owner, 0);
      chk("rst_i_done", i_done, 0);
      chk("rst_d_done", d_done, 0);
      reset = 0;
      step();

      // Fetch read, answered in the first BUSY cycle
      i_req = 1; i_addr = 32'h10;
      step();
      chk("fr_mem_valid", mem_valid, 1);
      chk("fr_mem_addr", mem_addr, 32'h10);
      chk("fr_mem_we", mem_we, 0);
      chk("fr_mem_wmask", mem_wmask, 0);
      mem_ready = 1; mem_rdata = 32'h005100E7;
      step();
      chk("fr_i_done", i_done, 1);
      chk("fr_i_rdata", i_rdata, 32'h005100E7);
      chk("fr_d_done", d_done, 0);
      i_req = 0; mem_ready = 0;
      step();
      chk("fr_idle", busy, 0);

      // Tie after reset, then round-robin alternation
      reset = 1; step(); reset = 0;
      i_req = 1; i_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h200;
      step();
      chk("tie1_owner", owner, 0);
      chk("tie1_addr", mem_addr, 32'h20);
      mem_ready = 1; mem_rdata = 32'h11111111;
      step();
      chk("tie1_i_done", i_done, 1);
      chk("tie1_d_done", d_done, 0);
      i_req = 0; mem_ready = 0;
      step();
      step();
      chk("tie2_owner", owner, 1);
      chk("tie2_addr", mem_addr, 32'h200);
      mem_ready = 1; mem_rdata = 32'h22222222;
      step();
      chk("tie2_d_done", d_done, 1);
      chk("tie2_d_rdata", d_rdata, 32'h22222222);
      i_req = 1; mem_ready = 0;
      step();
      step();
      chk("tie3_owner", owner, 0);
      mem_ready = 1;
      step();
      chk("tie3_i_done", i_done, 1);
      i_req = 0; d_req = 0; mem_ready = 0;
      step(); step();

      // Data write with three wait cycles; requester fields change after grant
      d_req = 1; d_we = 1; d_addr = 32'h104; d_wdata = 32'hDEADBEEF; d_wmask = 4'b0011;
      step();
      d_addr = 32'h999; d_wdata = 32'h0; d_wmask = 4'hF;
      for (int k = 1; k <= 4; k++) begin
         chk("wr_mem_valid", mem_valid, 1);
         chk("wr_mem_addr", mem_addr, 32'h104);
         chk("wr_mem_we", mem_we, 1);
         chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
         chk("wr_mem_wmask", mem_wmask, 4'b0011);
         mem_ready = (k == 4); mem_rdata = 32'h12345678;
         step();
      end
      chk("wr_d_done", d_done, 1);
      chk("wr_d_rdata", d_rdata, 0);
      chk("wr_d_err", d_err, 0);
      d_req = 0; mem_ready = 0;
      step(); step();

      // Timeout: memory never answers
      d_req = 1; d_we = 0; d_addr = 32'h300;
      step();
      busy_cnt = 0; n = 0;
      while (!d_done && n < 40) begin
         if (mem_valid) busy_cnt++;
         mem_rdata = $urandom;
         step();
         n++;
      end
      chk("to_busy_cycles", busy_cnt, 16);
      chk("to_d_done", d_done, 1);
      chk("to_d_err", d_err, 1);
      chk("to_d_rdata", d_rdata, 0);
      d_req = 0;
      step();
      chk("to_idle", busy, 0);

      // Ready in the 16th BUSY cycle still counts as success
      d_req = 1; d_addr = 32'h304;
      step();
      for (int k = 1; k <= 16; k++) begin
         mem_ready = (k == 16); mem_rdata = 32'hCAFEF00D;
         step();
      end
      chk("bd_d_done", d_done, 1);
      chk("bd_d_err", d_err, 0);
      chk("bd_d_rdata", d_rdata, 32'hCAFEF00D);
      d_req = 0; mem_ready = 0;
      step(); step();

      // Reset in the second BUSY cycle abandons the transaction
      i_req = 1; i_addr = 32'h40;
      step(); step();
      reset = 1;
      step();
      chk("rb_busy", busy, 0);
      chk("rb_mem_valid", mem_valid, 0);
      chk("rb_i_done", i_done, 0);
      reset = 0; d_req = 1; d_addr = 32'h400; i_addr = 32'h44;
      step();
      chk("rb_owner", owner, 0);
      chk("rb_addr", mem_addr, 32'h44);
      mem_ready = 1; mem_rdata = 32'h0BADF00D;
      step();
      chk("rb_i_done", i_done, 1);
      chk("rb_i_rdata", i_rdata, 32'h0BADF00D);
      i_req = 0; d_req = 0; mem_ready = 0;
      step(); step();

      // Randomized traffic
      stall = 0;
      for (int c = 0; c < 3000; c++) begin
         if (reset) begin
            i_req = 0; d_req = 0;
         end
         reset = ($urandom_range(0, 399) == 0);
         if (i_req && m_resp && !m_owner) begin
            if ($urandom_range(0, 9) < 6) i_req = 0;
            else i_addr = $urandom;
         end else if (!i_req && $urandom_range(0, 9) < 4) begin
            i_req = 1; i_addr = $urandom;
         end
         if (d_req && m_resp && m_owner) begin
            if ($urandom_range(0, 9) < 6) d_req = 0;
            else begin
               d_we = $urandom; d_addr = $urandom; d_wdata = $urandom; d_wmask = $urandom;
            end
         end else if (!d_req && $urandom_range(0, 9) < 4) begin
            d_req = 1; d_we = $urandom; d_addr = $urandom; d_wdata = $urandom; d_wmask = $urandom;
         end
         if (m_txn && !m_owner && i_req) i_addr = $urandom;
         if (m_txn && m_owner && d_req) begin
            d_addr = $urandom; d_wdata = $urandom; d_wmask = $urandom; d_we = $urandom;
         end
         if (!m_txn) stall = ($urandom_range(0, 7) == 0);
         mem_ready = !stall && ($urandom_range(0, 3) == 0);
         mem_rdata = $urandom;
         step();
      end
      reset = 0; i_req = 0; d_req = 0; mem_ready = 0;
      for (int k = 0; k < 25; k++) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
